// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit_if
// Brief    : Control/flag/LUT-write inputs and PC status outputs of branch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_pc_unit_if #(
   parameter int PC_W   = 10,
   parameter int LUT_AW = 5
);
   logic              start;
   logic [PC_W-1:0]   start_addr;
   logic              halt_req;
   logic              branch_en;
   logic [2:0]        cond;
   logic [LUT_AW-1:0] lut_idx;
   logic              call_en;
   logic              ret_en;
   logic              c_in;
   logic              v_in;
   logic              z_in;
   logic              lut_wr_en;
   logic [LUT_AW-1:0] lut_wr_idx;
   logic [PC_W-1:0]   lut_wr_data;
   logic [PC_W-1:0]   pc;
   logic              taken;
   logic              done;
   logic              stack_err;

   modport master (
      output start, start_addr, halt_req, branch_en, cond, lut_idx,
             call_en, ret_en, c_in, v_in, z_in,
             lut_wr_en, lut_wr_idx, lut_wr_data,
      input  pc, taken, done, stack_err
   );

   modport slave (
      input  start, start_addr, halt_req, branch_en, cond, lut_idx,
             call_en, ret_en, c_in, v_in, z_in,
             lut_wr_en, lut_wr_idx, lut_wr_data,
      output pc, taken, done, stack_err
   );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit
// Brief    : Next-PC selection with branch-target LUT, call/return stack and
//            IDLE/RUN/HALTED control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
   parameter int PC_W        = 10,
   parameter int LUT_AW      = 5,
   parameter int STACK_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   branch_pc_unit_if.slave    bus
);
   localparam int c_LUT_N = 2 ** LUT_AW;
   localparam int c_SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [1:0] c_S_IDLE   = 2'd0;
   localparam logic [1:0] c_S_RUN    = 2'd1;
   localparam logic [1:0] c_S_HALTED = 2'd2;

   logic [1:0]        r_state;
   logic [PC_W-1:0]   r_pc;
   logic              r_taken;
   logic              r_done;
   logic              r_stack_err;
   logic [c_SP_W-1:0] r_sp;
   logic [PC_W-1:0]   r_lut   [c_LUT_N];
   logic [PC_W-1:0]   r_stack [STACK_DEPTH];

   logic               w_cond_true;
   logic               w_stack_empty;
   logic               w_stack_full;
   logic [c_IDX_W-1:0] w_top_idx;
   logic [c_IDX_W-1:0] w_push_idx;
   logic [PC_W-1:0]    w_target;
   logic [PC_W-1:0]    w_pc_inc;
   logic               w_in_run;
   logic               w_push;

   always_comb begin
      w_cond_true = 1'b0;
      case (bus.cond)
         3'b000:  w_cond_true = 1'b1;
         3'b001:  w_cond_true = bus.z_in;
         3'b010:  w_cond_true = ~bus.z_in;
         3'b011:  w_cond_true = bus.c_in;
         3'b100:  w_cond_true = ~bus.c_in;
         3'b101:  w_cond_true = bus.v_in;
         3'b110:  w_cond_true = ~bus.v_in;
         default: w_cond_true = 1'b0;
      endcase
   end

   assign w_stack_empty = (r_sp == '0);
   assign w_stack_full  = (r_sp == c_SP_W'(STACK_DEPTH));
   assign w_top_idx     = c_IDX_W'(r_sp - c_SP_W'(1));
   assign w_push_idx    = c_IDX_W'(r_sp);
   // LUT read sees the pre-edge contents, so a same-cycle write is not forwarded
   assign w_target      = r_lut[bus.lut_idx];
   assign w_pc_inc      = r_pc + PC_W'(1);
   assign w_in_run      = (r_state == c_S_RUN);
   assign w_push        = w_in_run && !bus.halt_req && !bus.ret_en &&
                          bus.call_en && !w_stack_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_S_IDLE;
         r_pc        <= '0;
         r_taken     <= 1'b0;
         r_done      <= 1'b0;
         r_stack_err <= 1'b0;
         r_sp        <= '0;
         for (int i = 0; i < c_LUT_N; i++) begin
            r_lut[i] <= '0;
         end
      end else begin
         if (bus.lut_wr_en) begin
            r_lut[bus.lut_wr_idx] <= bus.lut_wr_data;
         end
         r_taken <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (bus.start) begin
                  r_state <= c_S_RUN;
                  r_pc    <= bus.start_addr;
               end
            end
            c_S_RUN: begin
               if (bus.halt_req) begin
                  r_state <= c_S_HALTED;
                  r_done  <= 1'b1;
               end else if (bus.ret_en) begin
                  if (w_stack_empty) begin
                     r_state     <= c_S_HALTED;
                     r_done      <= 1'b1;
                     r_stack_err <= 1'b1;
                  end else begin
                     r_pc    <= r_stack[w_top_idx];
                     r_sp    <= r_sp - c_SP_W'(1);
                     r_taken <= 1'b1;
                  end
               end else if (bus.call_en) begin
                  if (w_stack_full) begin
                     r_state     <= c_S_HALTED;
                     r_done      <= 1'b1;
                     r_stack_err <= 1'b1;
                  end else begin
                     r_pc    <= w_target;
                     r_sp    <= r_sp + c_SP_W'(1);
                     r_taken <= 1'b1;
                  end
               end else if (bus.branch_en && w_cond_true) begin
                  r_pc    <= w_target;
                  r_taken <= 1'b1;
               end else begin
                  r_pc <= w_pc_inc;
               end
            end
            c_S_HALTED: begin
               if (bus.start) begin
                  r_state     <= c_S_RUN;
                  r_pc        <= bus.start_addr;
                  r_done      <= 1'b0;
                  r_stack_err <= 1'b0;
                  r_sp        <= '0;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   // Stack contents need no reset: the pointer alone defines validity
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign bus.pc        = r_pc;
   assign bus.taken     = r_taken;
   assign bus.done      = r_done;
   assign bus.stack_err = r_stack_err;
endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pc_unit
// Brief    : Table-driven, scoreboard-checked bench for branch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;
   localparam logic [5:0] c_NOP   = 6'b000000;
   localparam logic [5:0] c_RST   = 6'b100000;
   localparam logic [5:0] c_START = 6'b010000;
   localparam logic [5:0] c_HALT  = 6'b001000;
   localparam logic [5:0] c_BR    = 6'b000100;
   localparam logic [5:0] c_CALL  = 6'b000010;
   localparam logic [5:0] c_RET   = 6'b000001;

   typedef struct {
      logic [5:0] ctl;
      logic [9:0] saddr;
      logic [2:0] cond;
      logic [4:0] idx;
      logic [2:0] cvz;
      logic       we;
      logic [4:0] widx;
      logic [9:0] wd;
      logic [9:0] epc;
      logic [2:0] etde;
   } vec_t;

   typedef struct {
      logic [9:0] pc;
      logic       t;
      logic       d;
      logic       e;
      string      name;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   exp_t exp_q[$];
   vec_t tbl[$];

   branch_pc_unit_if #(.PC_W(10), .LUT_AW(5)) bus ();

   branch_pc_unit #(.PC_W(10), .LUT_AW(5), .STACK_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [5:0] ctl, input logic [9:0] saddr,
                               input logic [2:0] cond, input logic [4:0] idx,
                               input logic [2:0] cvz, input logic we,
                               input logic [4:0] widx, input logic [9:0] wd,
                               input logic [9:0] epc, input logic [2:0] etde);
      vec_t v;
      v.ctl = ctl;   v.saddr = saddr; v.cond = cond; v.idx = idx;
      v.cvz = cvz;   v.we = we;       v.widx = widx; v.wd = wd;
      v.epc = epc;   v.etde = etde;
      return v;
   endfunction

   task automatic cmp(input string nm, input string fld, input logic [9:0] got,
                      input logic [9:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %s: got %h want %h", nm, fld, got, want);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      exp_t e;
      @(negedge clk);
      reset          = v.ctl[5];
      bus.start      = v.ctl[4];
      bus.halt_req   = v.ctl[3];
      bus.branch_en  = v.ctl[2];
      bus.call_en    = v.ctl[1];
      bus.ret_en     = v.ctl[0];
      bus.start_addr = v.saddr;
      bus.cond       = v.cond;
      bus.lut_idx    = v.idx;
      {bus.c_in, bus.v_in, bus.z_in} = v.cvz;
      bus.lut_wr_en   = v.we;
      bus.lut_wr_idx  = v.widx;
      bus.lut_wr_data = v.wd;
      e.pc = v.epc; e.t = v.etde[2]; e.d = v.etde[1]; e.e = v.etde[0]; e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard: got empty want entry", nm);
      end else begin
         e = exp_q.pop_front();
         cmp(e.name, "pc",        bus.pc,           e.pc);
         cmp(e.name, "taken",     10'(bus.taken),     10'(e.t));
         cmp(e.name, "done",      10'(bus.done),      10'(e.d));
         cmp(e.name, "stack_err", 10'(bus.stack_err), 10'(e.e));
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      bus.start = 0; bus.start_addr = '0; bus.halt_req = 0; bus.branch_en = 0;
      bus.cond = '0; bus.lut_idx = '0; bus.call_en = 0; bus.ret_en = 0;
      bus.c_in = 0; bus.v_in = 0; bus.z_in = 0;
      bus.lut_wr_en = 0; bus.lut_wr_idx = '0; bus.lut_wr_data = '0;

      // Reset, idle, sequential run, LUT branch per condition code, call/return
      tbl.push_back(mk(c_RST,          0,     0, 0, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_RST,          0,     0, 0, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_CALL | c_BR,  0,     0, 3, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_START,        10'h010, 0, 0, 0, 0, 0, 0,    10'h010, 3'b000));
      for (int i = 1; i <= 5; i++)
         tbl.push_back(mk(c_NOP,       0,     0, 0, 0, 0, 0, 0,      10'(10'h010 + i), 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 1, 3, 10'h200, 10'h016, 3'b000));
      tbl.push_back(mk(c_BR,           0,     1, 3, 3'b001, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h201, 3'b000));
      tbl.push_back(mk(c_BR,           0,     1, 3, 3'b000, 0, 0, 0, 10'h202, 3'b000));
      tbl.push_back(mk(c_BR,           0,     0, 3, 3'b000, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     7, 3, 3'b111, 0, 0, 0, 10'h201, 3'b000));
      tbl.push_back(mk(c_BR,           0,     3, 3, 3'b100, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     4, 3, 3'b100, 0, 0, 0, 10'h201, 3'b000));
      tbl.push_back(mk(c_BR,           0,     2, 3, 3'b000, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     5, 3, 3'b010, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     6, 3, 3'b010, 0, 0, 0, 10'h201, 3'b000));
      tbl.push_back(mk(c_BR,           0,     6, 3, 3'b000, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     4, 3, 3'b000, 0, 0, 0, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     2, 3, 3'b001, 0, 0, 0, 10'h201, 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 1, 4, 10'h050, 10'h202, 3'b000));
      tbl.push_back(mk(c_BR,           0,     0, 4, 0, 0, 0, 0,      10'h050, 3'b100));
      tbl.push_back(mk(c_START | c_CALL, 10'h3AB, 0, 3, 0, 0, 0, 0,  10'h200, 3'b100));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h201, 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h202, 3'b000));
      tbl.push_back(mk(c_RET,          0,     0, 0, 0, 0, 0, 0,      10'h051, 3'b100));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h052, 3'b000));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vecA%0d", i));

      // Nested calls: four fit, the fifth overflows and halts with pc held
      for (int i = 1; i <= 4; i++)
         apply(mk(c_CALL, 0, 0, 3, 0, 0, 0, 0, 10'h200, 3'b100), $sformatf("call%0d", i));
      apply(mk(c_CALL, 0, 0, 3, 0, 0, 0, 0, 10'h200, 3'b011), "call5_ovf");
      apply(mk(c_NOP,  0, 0, 0, 0, 0, 0, 0, 10'h200, 3'b011), "halted_hold");
      apply(mk(c_BR,   0, 0, 3, 0, 0, 0, 0, 10'h200, 3'b011), "halted_br_ign");

      tbl.delete();
      // Restart empties the stack, underflow, wrap, halt priority, LUT RAW, mid-run reset
      tbl.push_back(mk(c_START,        10'h100, 0, 0, 0, 0, 0, 0,    10'h100, 3'b000));
      tbl.push_back(mk(c_RET,          0,     0, 0, 0, 0, 0, 0,      10'h100, 3'b011));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h100, 3'b011));
      tbl.push_back(mk(c_START,        10'h3FF, 0, 0, 0, 0, 0, 0,    10'h3FF, 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h001, 3'b000));
      tbl.push_back(mk(c_HALT | c_RET | c_BR, 0, 0, 3, 0, 0, 0, 0,   10'h001, 3'b010));
      tbl.push_back(mk(c_NOP,          0,     0, 0, 0, 0, 0, 0,      10'h001, 3'b010));
      tbl.push_back(mk(c_START,        10'h020, 0, 0, 0, 0, 0, 0,    10'h020, 3'b000));
      tbl.push_back(mk(c_BR,           0,     0, 3, 0, 1, 3, 10'h123, 10'h200, 3'b100));
      tbl.push_back(mk(c_BR,           0,     0, 3, 0, 0, 0, 0,      10'h123, 3'b100));
      tbl.push_back(mk(c_CALL,         0,     0, 3, 0, 0, 0, 0,      10'h123, 3'b100));
      tbl.push_back(mk(c_RST | c_BR,   0,     0, 3, 0, 0, 0, 0,      10'h000, 3'b000));
      tbl.push_back(mk(c_START,        10'h030, 0, 0, 0, 0, 0, 0,    10'h030, 3'b000));
      tbl.push_back(mk(c_BR,           0,     0, 3, 0, 0, 0, 0,      10'h000, 3'b100));
      tbl.push_back(mk(c_RET,          0,     0, 0, 0, 0, 0, 0,      10'h000, 3'b011));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vecB%0d", i));

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
